// File: rtl/seq_pkg.sv
// Shared definitions for the sequencer core: opcodes, FSM states, field widths
// and a simulation-only name decode for state and opcode.
package seq_pkg;

    localparam int OPC_W = 4;
    localparam int CMD_W = 4;
    localparam int DST_W = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_LDR = 4'h2;
    localparam logic [3:0] OP_CMD = 4'h3;
    localparam logic [3:0] OP_DMP = 4'h4;
    localparam logic [3:0] OP_EQI = 4'h5;
    localparam logic [3:0] OP_EQR = 4'h6;
    localparam logic [3:0] OP_JXI = 4'h7;
    localparam logic [3:0] OP_JXR = 4'h8;
    localparam logic [3:0] OP_JZI = 4'h9;
    localparam logic [3:0] OP_JZR = 4'hA;
    localparam logic [3:0] OP_CAL = 4'hB;
    localparam logic [3:0] OP_RET = 4'hC;
    localparam logic [3:0] OP_WAT = 4'hD;
    localparam logic [3:0] OP_ADI = 4'hE;
    localparam logic [3:0] OP_ILL = 4'hF;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

`ifndef SYNTHESIS
    function automatic string state_name(input state_e s);
        case (s)
            ST_RESET: state_name = "RESET";
            ST_READY: state_name = "READY";
            ST_WAIT:  state_name = "WAIT";
            ST_ERROR: state_name = "ERROR";
            default:  state_name = "UNKNOWN";
        endcase
    endfunction

    function automatic string op_name(input logic [3:0] op);
        case (op)
            OP_NOP:  op_name = "NOP";
            OP_LDI:  op_name = "LDI";
            OP_LDR:  op_name = "LDR";
            OP_CMD:  op_name = "CMD";
            OP_DMP:  op_name = "DMP";
            OP_EQI:  op_name = "EQI";
            OP_EQR:  op_name = "EQR";
            OP_JXI:  op_name = "JXI";
            OP_JXR:  op_name = "JXR";
            OP_JZI:  op_name = "JZI";
            OP_JZR:  op_name = "JZR";
            OP_CAL:  op_name = "CAL";
            OP_RET:  op_name = "RET";
            OP_WAT:  op_name = "WAT";
            OP_ADI:  op_name = "ADI";
            OP_ILL:  op_name = "ILL";
            default: op_name = "???";
        endcase
    endfunction
`endif

endpackage

// File: rtl/seq_stack.sv
// Return-address stack for CAL/RET; top reads as zero when the stack is empty.
module seq_stack #(
    parameter int AW     = 8,
    parameter int SDEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [AW-1:0] top
);

    localparam int PW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;
    localparam int CW = $clog2(SDEPTH + 1);

    logic [AW-1:0] mem_r [SDEPTH];
    logic [CW-1:0] cnt_r;
    logic [PW-1:0] wr_idx_s;
    logic [PW-1:0] rd_idx_s;

    assign full     = (cnt_r == CW'(SDEPTH));
    assign empty    = (cnt_r == CW'(0));
    assign wr_idx_s = PW'(cnt_r);
    assign rd_idx_s = PW'(cnt_r - CW'(1));
    assign top      = empty ? AW'(0) : mem_r[rd_idx_s];

    // Entry storage and occupancy count; overflow/underflow requests are ignored.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= CW'(0);
            for (int i = 0; i < SDEPTH; i++) begin
                mem_r[i] <= AW'(0);
            end
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= din;
            cnt_r           <= cnt_r + CW'(1);
        end else if (pop && !empty) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/seq_core.sv
// Single-issue instruction sequencer: one transfer register T, a program
// address, a call stack and one-hot strobed output registers.
module seq_core
    import seq_pkg::*;
#(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int NIN    = 4,
    parameter int NOUT   = 8,
    parameter int SDEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [OPC_W+DW-1:0]   inst,
    input  logic                  inst_valid,
    output logic                  inst_ready,
    input  logic [NIN*DW-1:0]     ireg,
    output logic [AW-1:0]         next,
    output logic [OPC_W+DW-1:0]   oreg,
    output logic [NOUT-1:0]       oreg_wen,
    output logic                  error
);

    localparam int SW = $clog2(NIN);

    state_e                 state_r;
    logic [DW-1:0]          t_r;
    logic [AW-1:0]          next_r;
    logic [OPC_W+DW-1:0]    oreg_r;
    logic [NOUT-1:0]        wen_r;
    logic                   error_r;
    logic [SW-1:0]          wait_src_r;

    logic [3:0]             opcode_s;
    logic [DW-1:0]          imm_s;
    logic [CMD_W-1:0]       cmd_s;
    logic [SW-1:0]          src_s;
    logic [DST_W-1:0]       dst_s;
    logic [DW-1:0]          src_val_s;
    logic [DW-1:0]          wait_val_s;
    logic                   dst_bad_s;
    logic [NOUT-1:0]        onehot_s;
    logic [AW-1:0]          next_inc_s;
    logic                   accept_s;

    state_e                 state_d_s;
    logic [DW-1:0]          t_d_s;
    logic [AW-1:0]          next_d_s;
    logic [OPC_W+DW-1:0]    oreg_d_s;
    logic [NOUT-1:0]        wen_d_s;
    logic                   err_d_s;
    logic                   push_s;
    logic                   pop_s;

    logic                   stk_full_s;
    logic                   stk_empty_s;
    logic [AW-1:0]          stk_top_s;

    function automatic logic [DW-1:0] pick_word(input logic [NIN*DW-1:0] bus,
                                                input logic [SW-1:0] idx);
        pick_word = bus[int'(idx)*DW +: DW];
    endfunction

    assign opcode_s   = inst[OPC_W+DW-1:DW];
    assign imm_s      = inst[DW-1:0];
    assign cmd_s      = imm_s[DW-1:DW-CMD_W];
    assign src_s      = imm_s[SW-1:0];
    assign dst_s      = imm_s[DST_W-1:0];
    assign src_val_s  = pick_word(ireg, src_s);
    assign wait_val_s = pick_word(ireg, wait_src_r);
    assign dst_bad_s  = (int'(dst_s) >= NOUT);
    assign onehot_s   = NOUT'(1) << dst_s;
    assign next_inc_s = next_r + AW'(1);

    // Reset has priority, so ready is masked combinationally by it.
    assign inst_ready = (state_r == ST_READY) && !reset;
    assign accept_s   = inst_valid && inst_ready;

    assign next     = next_r;
    assign oreg     = oreg_r;
    assign oreg_wen = wen_r;
    assign error    = error_r;

    seq_stack #(
        .AW     (AW),
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clock (clock),
        .reset (reset),
        .push  (accept_s && push_s),
        .pop   (accept_s && pop_s),
        .din   (next_inc_s),
        .full  (stk_full_s),
        .empty (stk_empty_s),
        .top   (stk_top_s)
    );

    // Instruction decode: the result of executing the presented instruction.
    always_comb begin
        state_d_s = ST_READY;
        t_d_s     = t_r;
        next_d_s  = next_inc_s;
        oreg_d_s  = '0;
        wen_d_s   = '0;
        err_d_s   = 1'b0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (opcode_s)
            OP_NOP: next_d_s = next_inc_s;
            OP_LDI: t_d_s = imm_s;
            OP_LDR: t_d_s = src_val_s;
            OP_CMD: begin
                if (dst_bad_s) begin
                    err_d_s = 1'b1;
                end else begin
                    oreg_d_s = {cmd_s, t_r};
                    wen_d_s  = onehot_s;
                end
            end
            OP_DMP: begin
                if (dst_bad_s) begin
                    err_d_s = 1'b1;
                end else begin
                    oreg_d_s = {4'h0, t_r};
                    wen_d_s  = onehot_s;
                end
            end
            OP_EQI: t_d_s = DW'(t_r == imm_s);
            OP_EQR: t_d_s = DW'(t_r == src_val_s);
            OP_JXI: next_d_s = imm_s[AW-1:0];
            OP_JXR: next_d_s = src_val_s[AW-1:0];
            OP_JZI: begin
                if (t_r == DW'(0)) begin
                    next_d_s = imm_s[AW-1:0];
                end else begin
                    next_d_s = next_inc_s;
                end
            end
            OP_JZR: begin
                if (t_r == DW'(0)) begin
                    next_d_s = src_val_s[AW-1:0];
                end else begin
                    next_d_s = next_inc_s;
                end
            end
            OP_CAL: begin
                if (stk_full_s) begin
                    err_d_s = 1'b1;
                end else begin
                    push_s   = 1'b1;
                    next_d_s = imm_s[AW-1:0];
                end
            end
            OP_RET: begin
                if (stk_empty_s) begin
                    err_d_s = 1'b1;
                end else begin
                    pop_s    = 1'b1;
                    next_d_s = stk_top_s;
                end
            end
            OP_WAT: begin
                state_d_s = ST_WAIT;
                next_d_s  = next_r;
            end
            OP_ADI: t_d_s = t_r + imm_s;
            OP_ILL: err_d_s = 1'b1;
            default: err_d_s = 1'b1;
        endcase
    end

    // Control FSM with registered outputs; output strobes last a single cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_RESET;
            t_r        <= DW'(0);
            next_r     <= AW'(0);
            oreg_r     <= '0;
            wen_r      <= '0;
            error_r    <= 1'b0;
            wait_src_r <= SW'(0);
        end else begin
            case (state_r)
                ST_RESET: begin
                    state_r <= ST_READY;
                    oreg_r  <= '0;
                    wen_r   <= '0;
                end
                ST_READY: begin
                    if (inst_valid && err_d_s) begin
                        state_r <= ST_ERROR;
                        next_r  <= AW'(0);
                        oreg_r  <= '0;
                        wen_r   <= '0;
                        error_r <= 1'b1;
                    end else if (inst_valid) begin
                        state_r    <= state_d_s;
                        t_r        <= t_d_s;
                        next_r     <= next_d_s;
                        oreg_r     <= oreg_d_s;
                        wen_r      <= wen_d_s;
                        wait_src_r <= src_s;
                    end else begin
                        oreg_r <= '0;
                        wen_r  <= '0;
                    end
                end
                ST_WAIT: begin
                    oreg_r <= '0;
                    wen_r  <= '0;
                    if (wait_val_s != DW'(0)) begin
                        next_r  <= next_inc_s;
                        state_r <= ST_READY;
                    end else begin
                        next_r <= next_r;
                    end
                end
                ST_ERROR: begin
                    next_r  <= AW'(0);
                    oreg_r  <= '0;
                    wen_r   <= '0;
                    error_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_ERROR;
                    next_r  <= AW'(0);
                    oreg_r  <= '0;
                    wen_r   <= '0;
                    error_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_core.sv
// Scoreboard bench for seq_core: a behavioural ISA model queues the expected
// post-edge outputs, which are popped and compared on the following negedge.
module tb_seq_core;
    import seq_pkg::*;

    localparam int DW = 8, AW = 8, NIN = 4, NOUT = 8, SDEPTH = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [11:0]         inst;
    logic                inst_valid;
    logic                inst_ready;
    logic [NIN*DW-1:0]   ireg;
    logic [AW-1:0]       next;
    logic [11:0]         oreg;
    logic [NOUT-1:0]     oreg_wen;
    logic                error;

    always #5 clock = ~clock;

    seq_core #(.DW(DW), .AW(AW), .NIN(NIN), .NOUT(NOUT), .SDEPTH(SDEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .ireg       (ireg),
        .next       (next),
        .oreg       (oreg),
        .oreg_wen   (oreg_wen),
        .error      (error)
    );

    typedef struct packed {
        logic [7:0]  nxt;
        logic [11:0] org;
        logic [7:0]  wen;
        logic        err;
        logic        rdy;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_mis = 0;

    // reference model state: 0 RESET, 1 READY, 2 WAIT, 3 ERROR
    int         m_state = 0;
    logic [7:0] m_t = 8'h00;
    logic [7:0] m_next = 8'h00;
    logic       m_err = 1'b0;
    logic [1:0] m_wsrc = 2'd0;
    logic [7:0] m_stk[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [11:0] mk(input logic [3:0] op, input logic [7:0] imm);
        mk = {op, imm};
    endfunction

    function automatic logic [7:0] iw(input logic [1:0] k);
        iw = ireg[int'(k)*8 +: 8];
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        exp_t       e;
        logic [3:0] op;
        logic [7:0] imm;
        logic [7:0] nx;
        logic [11:0] o;
        logic [7:0] w;
        logic       bad;
        op  = inst[11:8];
        imm = inst[7:0];
        nx  = m_next + 8'd1;
        o   = 12'h000;
        w   = 8'h00;
        bad = 1'b0;
        if (reset) begin
            m_state = 0; m_t = 8'h00; m_next = 8'h00; m_err = 1'b0;
            m_stk.delete();
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (inst_valid) begin
                    case (op)
                        4'h0: m_next = nx;
                        4'h1: begin m_t = imm; m_next = nx; end
                        4'h2: begin m_t = iw(imm[1:0]); m_next = nx; end
                        4'h3, 4'h4: begin
                            if (imm[3:0] >= 4'd8) bad = 1'b1;
                            else begin
                                o = (op == 4'h3) ? {imm[7:4], m_t} : {4'h0, m_t};
                                w = 8'h01 << imm[3:0];
                                m_next = nx;
                            end
                        end
                        4'h5: begin m_t = (m_t == imm) ? 8'h01 : 8'h00; m_next = nx; end
                        4'h6: begin m_t = (m_t == iw(imm[1:0])) ? 8'h01 : 8'h00; m_next = nx; end
                        4'h7: m_next = imm;
                        4'h8: m_next = iw(imm[1:0]);
                        4'h9: m_next = (m_t == 8'h00) ? imm : nx;
                        4'hA: m_next = (m_t == 8'h00) ? iw(imm[1:0]) : nx;
                        4'hB: begin
                            if (m_stk.size() >= SDEPTH) bad = 1'b1;
                            else begin m_stk.push_back(nx); m_next = imm; end
                        end
                        4'hC: begin
                            if (m_stk.size() == 0) bad = 1'b1;
                            else m_next = m_stk.pop_back();
                        end
                        4'hD: begin m_state = 2; m_wsrc = imm[1:0]; end
                        4'hE: begin m_t = m_t + imm; m_next = nx; end
                        default: bad = 1'b1;
                    endcase
                    if (bad) begin
                        m_state = 3; m_next = 8'h00; m_err = 1'b1; o = 12'h000; w = 8'h00;
                    end
                end
                2: if (iw(m_wsrc) != 8'h00) begin m_next = nx; m_state = 1; end
                default: m_next = 8'h00;
            endcase
        end
        e.nxt = m_next; e.org = o; e.wen = w; e.err = m_err;
        e.rdy = (m_state == 1) && !reset;
        sb.push_back(e);
    endtask

    task automatic step(input logic r, input logic v, input logic [11:0] i);
        exp_t e;
        reset = r; inst_valid = v; inst = i;
        model_edge();
        @(posedge clock);
        @(negedge clock);
        e = sb.pop_front();
        check("next", next, e.nxt);
        check("oreg", oreg, e.org);
        check("oreg_wen", oreg_wen, e.wen);
        check("error", error, e.err);
        check("inst_ready", inst_ready, e.rdy);
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r, v;
        logic [3:0] op;
        reset = 1'b1; inst_valid = 1'b0; inst = 12'h000; ireg = '0;
        @(negedge clock);

        step(1'b1, 1'b0, 12'h000);
        step(1'b1, 1'b1, mk(OP_LDI, 8'h11));
        check("rst_next", next, 8'h00);
        check("rst_ready", inst_ready, 1'b0);
        step(1'b0, 1'b0, 12'h000);
        check("ready_after_reset", inst_ready, 1'b1);

        step(1'b0, 1'b1, mk(OP_LDI, 8'h5A));
        step(1'b0, 1'b1, mk(OP_CMD, 8'h32));
        check("cmd_oreg", oreg, 12'h35A);
        check("cmd_wen", oreg_wen, 8'h04);
        check("cmd_next", next, 8'h02);
        step(1'b0, 1'b0, 12'h000);
        check("cmd_wen_pulse", oreg_wen, 8'h00);

        restart();
        step(1'b0, 1'b1, mk(OP_LDI, 8'h00));
        step(1'b0, 1'b1, mk(OP_JZI, 8'h40));
        check("jzi_taken", next, 8'h40);
        step(1'b0, 1'b1, mk(OP_LDI, 8'h01));
        step(1'b0, 1'b1, mk(OP_JXI, 8'h10));
        step(1'b0, 1'b1, mk(OP_JZI, 8'h40));
        check("jzi_not_taken", next, 8'h11);

        restart();
        step(1'b0, 1'b1, mk(OP_JXI, 8'h05));
        step(1'b0, 1'b1, mk(OP_CAL, 8'h20));
        check("cal_next", next, 8'h20);
        step(1'b0, 1'b1, mk(OP_RET, 8'h00));
        check("ret_next", next, 8'h06);
        for (int k = 0; k <= SDEPTH; k++) step(1'b0, 1'b1, mk(OP_CAL, 8'h30));
        check("overflow_error", error, 1'b1);
        check("overflow_ready", inst_ready, 1'b0);

        restart();
        step(1'b0, 1'b1, mk(OP_WAT, 8'h03));
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, mk(OP_JXI, 8'h77));
        check("wait_ready", inst_ready, 1'b0);
        check("wait_next", next, 8'h00);
        ireg[31:24] = 8'h01;
        step(1'b0, 1'b0, 12'h000);
        check("wait_done_next", next, 8'h01);
        check("wait_done_ready", inst_ready, 1'b1);

        restart();
        step(1'b0, 1'b1, mk(OP_LDI, 8'hF0));
        step(1'b0, 1'b1, mk(OP_ADI, 8'h20));
        step(1'b0, 1'b1, mk(OP_DMP, 8'h01));
        check("adi_wrap", oreg, 12'h010);
        step(1'b0, 1'b1, mk(OP_JXI, 8'hFF));
        step(1'b0, 1'b1, mk(OP_NOP, 8'h00));
        check("next_wrap", next, 8'h00);

        ireg = 32'hA0_44_07_33;
        step(1'b0, 1'b1, mk(OP_LDR, 8'h01));
        step(1'b0, 1'b1, mk(OP_EQR, 8'h01));
        step(1'b0, 1'b1, mk(OP_DMP, 8'h07));
        check("eqr_true", oreg, 12'h001);
        step(1'b0, 1'b1, mk(OP_EQI, 8'h05));
        step(1'b0, 1'b1, mk(OP_JZR, 8'h02));
        check("jzr_taken", next, 8'h44);
        step(1'b0, 1'b1, mk(OP_JXR, 8'h00));
        check("jxr", next, 8'h33);
        step(1'b0, 1'b1, mk(OP_DMP, 8'h09));
        check("dst_range_error", error, 1'b1);

        restart();
        step(1'b0, 1'b1, mk(OP_RET, 8'h00));
        check("underflow_error", error, 1'b1);

        restart();
        step(1'b0, 1'b1, mk(OP_LDI, 8'h01));
        step(1'b0, 1'b1, mk(OP_ILL, 8'h00));
        check("ill_error", error, 1'b1);
        check("ill_oreg", oreg, 12'h000);
        step(1'b0, 1'b1, mk(OP_DMP, 8'h00));
        step(1'b1, 1'b0, 12'h000);
        check("err_reset_error", error, 1'b0);
        check("err_reset_next", next, 8'h00);
        step(1'b0, 1'b0, 12'h000);
        check("err_reset_ready", inst_ready, 1'b1);

        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 59) == 0) || (m_state == 3 && $urandom_range(0, 3) == 0);
            v  = ($urandom_range(0, 3) != 0);
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h0;
            if ($urandom_range(0, 7) == 0) ireg = $urandom;
            inst = mk(op, 8'($urandom_range(0, 255)));
            if ((op == 4'h3 || op == 4'h4) && $urandom_range(0, 3) != 0) inst[3] = 1'b0;
            step(r, v, inst);
        end

        $display("final core state %s", state_name(dut.state_r));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/seq_core.md
SEQ_CORE -- requirements
Module: seq_core

Interface
REQ-001 Parameter DW, default 8: transfer/immediate data width, 4..16.
REQ-002 Parameter AW, default 8: program address width, 1..DW.
REQ-003 Parameter NIN, default 4: input register count, power of 2, 2..16.
REQ-004 Parameter NOUT, default 8: output register count, 2..16.
REQ-005 Parameter SDEPTH, default 4: call stack depth, 1..16.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 inst  in  4+DW  instruction: [4+DW-1:DW] opcode, [DW-1:0] imm; cmd=imm[DW-1:DW-4], src=imm[log2(NIN)-1:0], dst=imm[3:0].
REQ-009 inst_valid  in  1  inst is presented.
REQ-010 inst_ready  out  1  core accepts inst this cycle; transfer occurs when valid and ready are both high.
REQ-011 ireg  in  NIN*DW  packed input registers; ireg[k] = bits [k*DW+DW-1:k*DW].
REQ-012 next  out  AW  registered program address to fetch.
REQ-013 oreg  out  4+DW  registered output data.
REQ-014 oreg_wen  out  NOUT  registered one-hot output write enable.
REQ-015 error  out  1  registered sticky error flag.

Function
REQ-016 States: RESET, READY, WAIT, ERROR; RESET->READY unconditionally after one cycle.
REQ-017 inst_ready SHALL be high only in READY.
REQ-018 Accepted instruction updates T (transfer, DW bits), next, oreg and oreg_wen on the same clock edge; latency 1 cycle.
REQ-019 In any cycle without an accepted instruction, oreg and oreg_wen SHALL be 0, T and next SHALL hold.
REQ-020 Opcodes, with next=next+1 unless stated and oreg/wen=0 unless stated: 0 NOP; 1 LDI T=imm; 2 LDR T=ireg[src]; 3 CMD oreg={cmd,T}, wen=onehot(dst); 4 DMP oreg={4'h0,T}, wen=onehot(dst); 5 EQI T=(T==imm); 6 EQR T=(T==ireg[src]).
REQ-021 7 JXI next=imm[AW-1:0]; 8 JXR next=ireg[src][AW-1:0]; 9 JZI/A JZR same targets only if T==0, else next+1.
REQ-022 B CAL push next+1 to stack, next=imm[AW-1:0]; C RET pop stack into next.
REQ-023 D WAT enter WAIT; in WAIT, when ireg[src] (src captured at accept) is nonzero, next=next+1 and return to READY; else hold.
REQ-024 E ADI T=(T+imm) mod 2^DW; carry discarded.
REQ-025 Address increment SHALL wrap modulo 2^AW.
REQ-026 CMD/DMP with dst>=NOUT, opcode F, CAL with stack full (SDEPTH entries), RET with stack empty SHALL enter ERROR and set error=1.
REQ-027 ERROR is absorbing until reset; in ERROR next, oreg, oreg_wen SHALL be 0 and T, stack unchanged.
REQ-028 No output SHALL ever be driven to X or Z.

Reset
REQ-029 reset sampled high at a clock edge SHALL force state RESET, T=0, next=0, oreg=0, oreg_wen=0, error=0, stack empty, regardless of state (including WAIT and ERROR).
REQ-030 reset SHALL take priority over an instruction accepted in the same cycle; inst_ready=0 while reset is high.

Structure
REQ-031 Opcode constants, state enumeration and field-position constants SHALL reside in shared package seq_pkg.
REQ-032 Call stack SHALL be sub-module seq_stack (params AW, SDEPTH; push, pop, full, empty, top).
REQ-033 A debug string decode of state and opcode SHALL be simulation-only, excluded from synthesis.

Verification
REQ-034 Reset, then LDI 0x5A, CMD cmd=0x3 dst=2 -> oreg=0x35A, oreg_wen=0x04 for one cycle, next=2.
REQ-035 T=0, JZI 0x40 -> next=0x40; T=1, JZI 0x40 at address 0x10 -> next=0x11.
REQ-036 CAL 0x20 at address 0x05, RET -> next=0x20 then 0x06; SDEPTH+1 nested CALs -> error=1, inst_ready=0.
REQ-037 WAT src=3, ireg[3]=0 for 5 cycles -> inst_ready=0, next held; ireg[3]=0x01 -> next+1, inst_ready=1 next cycle.
REQ-038 T=0xF0, ADI 0x20 -> T=0x10; next=0xFF, NOP -> next=0x00.
REQ-039 Opcode F -> error=1, outputs 0; reset asserted in ERROR -> error=0, next=0 and READY after one cycle.
